// File: rtl/csa42_row_accum.sv
// Row of WIDTH 4:2 carry-save compressor cells with a registered (ws,wc) output and valid/ready handshakes.
// Optional macro CSA42_RESOLVE_EN adds a resolved sum output (ws+wc).
module csa42_row_accum #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic             clear,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ws,
    output logic [WIDTH-1:0] wc
`ifdef CSA42_RESOLVE_EN
    ,
    output logic [WIDTH-1:0] sum
`endif
);

    logic [WIDTH-1:0] ws_reg;
    logic [WIDTH-1:0] wc_reg;
    logic             out_valid_reg;

    logic [WIDTH-1:0] ws_next;
    logic [WIDTH-1:0] wc_next;
    logic [WIDTH-1:0] st_ws;
    logic [WIDTH-1:0] st_wc;
    logic [WIDTH-1:0] op_p;
    logic [WIDTH-1:0] op_q;
    logic [WIDTH-1:0] op_r;
    logic [WIDTH-1:0] op_t;
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] h_in;
    logic [WIDTH-2:0] h;
    logic [WIDTH-2:0] c2;
    logic             accept;

    assign in_ready = !out_valid_reg || out_ready;
    assign accept   = in_valid && in_ready;

    // A clear on the accepting beat makes the accumulator look empty for that beat.
    always_comb begin
        st_ws = clear ? '0 : ws_reg;
        st_wc = clear ? '0 : wc_reg;
        op_p  = a;
        op_q  = b;
        op_r  = c;
        op_t  = d;
        if (mode) begin
            op_r = st_ws << 1;
            op_t = st_wc << 1;
        end
    end

    assign h_in    = {h, 1'b0};
    assign wc_next = {c2, 1'b0};

    // The MSB cell's carries leave the word, so only its sum bits are formed.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            if (gi == WIDTH - 1) begin : g_msb
                assign s1[gi]      = op_p[gi] ^ op_q[gi] ^ op_r[gi];
                assign ws_next[gi] = s1[gi] ^ op_t[gi] ^ h_in[gi];
            end else begin : g_full
                assign {h[gi], s1[gi]} = {1'b0, op_p[gi]} + {1'b0, op_q[gi]} + {1'b0, op_r[gi]};
                assign {c2[gi], ws_next[gi]} = {1'b0, s1[gi]} + {1'b0, op_t[gi]} + {1'b0, h_in[gi]};
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ws_reg        <= '0;
            wc_reg        <= '0;
            out_valid_reg <= 1'b0;
        end else if (accept) begin
            ws_reg        <= ws_next;
            wc_reg        <= wc_next;
            out_valid_reg <= 1'b1;
        end else if (clear) begin
            ws_reg        <= '0;
            wc_reg        <= '0;
            out_valid_reg <= 1'b0;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign ws        = ws_reg;
    assign wc        = wc_reg;
    assign out_valid = out_valid_reg;

`ifdef CSA42_RESOLVE_EN
    assign sum = ws_reg + wc_reg;
`endif

endmodule

// File: tb/tb_csa42_row_accum.sv
// Randomised scoreboard bench for csa42_row_accum: an arithmetic model predicts each accepted
// result, a monitor pops and compares when the DUT presents it.
module tb_csa42_row_accum;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             mode;
    logic             clear;
    logic [WIDTH-1:0] a, b, c, d;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ws, wc;
`ifdef CSA42_RESOLVE_EN
    logic [WIDTH-1:0] sum;
`endif

    csa42_row_accum #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .clear     (clear),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ws        (ws),
        .wc        (wc)
`ifdef CSA42_RESOLVE_EN
        ,
        .sum       (sum)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] m_acc;
    bit               m_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic check_state();
        logic [WIDTH-1:0] res;
        res = ws + wc;
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("ws_plus_wc", {24'd0, res}, {24'd0, m_acc});
        chk("wc_lsb", {31'd0, wc[0]}, 32'd0);
`ifdef CSA42_RESOLVE_EN
        chk("sum", {24'd0, sum}, {24'd0, m_acc});
`endif
    endtask

    // One cycle of stimulus; the model follows the arithmetic rules, not the cell structure.
    task automatic drive(input bit iv, input bit md, input bit clr,
                         input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                         input logic [WIDTH-1:0] tc, input logic [WIDTH-1:0] td,
                         input bit ordy);
        logic [WIDTH-1:0] val;
        bit exp_rdy;
        @(negedge clk);
        in_valid  = iv;
        mode      = md;
        clear     = clr;
        a         = ta;
        b         = tb_;
        c         = tc;
        d         = td;
        out_ready = ordy;
        #1;
        check_state();
        exp_rdy = !m_valid || ordy;
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        if (iv && exp_rdy) begin
            if (md) val = ta + tb_ + (clr ? 8'd0 : 8'(2 * int'(m_acc)));
            else    val = ta + tb_ + tc + td;
            exp_q.push_back(val);
            $display("beat mode=%0d clear=%0d a=%0d b=%0d c=%0d d=%0d -> expect %0d",
                     md, clr, ta, tb_, tc, td, val);
            m_acc   = val;
            m_valid = 1'b1;
        end else if (clr) begin
            m_acc   = '0;
            m_valid = 1'b0;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
    endtask

    // Monitor: a beat seen accepted before an edge must be presented after it.
    initial begin
        bit pend;
        logic [WIDTH-1:0] exp;
        logic [WIDTH-1:0] res;
        forever begin
            @(negedge clk);
            #2;
            pend = in_valid && in_ready && rst_n;
            @(posedge clk);
            #1;
            if (pend) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_result", 32'd1, 32'd0);
                end else begin
                    exp = exp_q.pop_front();
                    res = ws + wc;
                    chk("sb_valid", {31'd0, out_valid}, 32'd1);
                    chk("sb_result", {24'd0, res}, {24'd0, exp});
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; mode = 1'b0; clear = 1'b0;
        a = '0; b = '0; c = '0; d = '0; out_ready = 1'b0;
        m_acc = '0; m_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_state();
        rst_n = 1'b1;

        // Four-operand compress, then backpressure hold, then release.
        drive(1, 0, 0, 8'd3, 8'd5, 8'd7, 8'd9, 1);
        repeat (5) drive(1, 0, 0, 8'd10, 8'd20, 8'd30, 8'd40, 0);
        drive(1, 0, 0, 8'd10, 8'd20, 8'd30, 8'd40, 1);

        // Clear then accumulate 1, 3, 7.
        drive(0, 0, 1, 8'd0, 8'd0, 8'd0, 8'd0, 1);
        repeat (3) drive(1, 1, 0, 8'd1, 8'd0, 8'd0, 8'd0, 1);

        // Clear on an accepted mode-1 beat loads a+b; then doubling.
        drive(1, 1, 1, 8'd2, 8'd3, 8'd0, 8'd0, 1);
        drive(1, 1, 0, 8'd0, 8'd0, 8'd0, 8'd0, 1);

        // All-ones wrap.
        drive(1, 0, 0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1);
        drive(0, 0, 0, 8'd0, 8'd0, 8'd0, 8'd0, 1);

        // Async reset between edges while a result is held.
        drive(1, 1, 0, 8'd9, 8'd4, 8'd0, 8'd0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_ws", {24'd0, ws}, 32'd0);
        chk("rst_wc", {24'd0, wc}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        exp_q.delete();
        m_acc = '0;
        m_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 1, 0, 8'd4, 8'd1, 8'd0, 8'd0, 1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0,
                  8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                  $urandom_range(0, 3) != 0);
        end
        drive(0, 0, 0, 8'd0, 8'd0, 8'd0, 8'd0, 1);
        @(negedge clk);
        #3;
        chk("sb_queue_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
